// File: rtl/fp_div_pkg.sv
// Shared definitions for the restoring mantissa divider: FSM states, ALU
// opcodes and default register/iteration sizes used across the divide path.
package fp_div_pkg;

  localparam int DEF_SIZE = 26;
  localparam int DEF_ITER = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    SUB,
    TEST,
    DONE
  } state_e;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/fp_div_iter_counter.sv
// Loadable down-counter of remaining divide iterations; saturates at zero and
// flags the last iteration so the FSM can leave the loop on time.
module fp_div_iter_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_next_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o       = cnt_q;
  assign zero_next_o = (cnt_q == W'(1));

endmodule

// File: rtl/fp_div_sequencer.sv
// Control FSM for the restoring mantissa divider: drives A/Q/B load and shift
// strobes and the shared add/sub unit through ITER shift/subtract/restore steps.
module fp_div_sequencer
  import fp_div_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int ITER = DEF_ITER,
  parameter int CW   = $clog2(ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          divisor_zero,
  input  logic          a_sign,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic          ld_a,
  output logic          ld_q,
  output logic          ld_b,
  output logic          sld_a,
  output logic          sld_q,
  output logic          alu_sub,
  output logic          qbit_wr,
  output logic          qbit,
  output logic [CW-1:0] iter_cnt
);

  // The remainder register needs room for the quotient width plus sign/guard.
  if (ITER > SIZE) begin : g_iter_too_wide
    $error("fp_div_sequencer: ITER exceeds register width SIZE");
  end

  state_e state_q, state_d;
  logic   dz_q, dz_d;
  logic   cnt_load, cnt_dec, last_iter;

  fp_div_iter_counter #(
    .W(CW)
  ) u_iter_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (CW'(ITER)),
    .cnt_o      (iter_cnt),
    .zero_next_o(last_iter)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          dz_d    = 1'b0;
        end
      end
      LOAD: begin
        if (divisor_zero) begin
          state_d = DONE;
          dz_d    = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT:   state_d = SUB;
      SUB:     state_d = TEST;
      TEST:    state_d = last_iter ? DONE : SHIFT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Negative remainder after SUB means B did not fit: restore via A+B, qbit=0.
  always_comb begin
    busy     = (state_q != IDLE);
    done     = 1'b0;
    ld_a     = 1'b0;
    ld_q     = 1'b0;
    ld_b     = 1'b0;
    sld_a    = 1'b0;
    sld_q    = 1'b0;
    alu_sub  = ALU_ADD;
    qbit_wr  = 1'b0;
    qbit     = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      LOAD: begin
        ld_a     = 1'b1;
        ld_q     = 1'b1;
        ld_b     = 1'b1;
        cnt_load = 1'b1;
      end
      SHIFT: begin
        sld_a = 1'b1;
        sld_q = 1'b1;
      end
      SUB: begin
        ld_a    = 1'b1;
        alu_sub = ALU_SUB;
      end
      TEST: begin
        qbit_wr = 1'b1;
        cnt_dec = 1'b1;
        ld_a    = a_sign;
        alu_sub = ALU_ADD;
        qbit    = ~a_sign;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign dz = dz_q;

endmodule
